// File: rtl/cnn_pkg.sv
// Shared types and tag widths for the CNN network sequencer and its output row buffer.
package cnn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        NEXT,
        DRAIN,
        DONE
    } seq_state_t;

    localparam int FEAT_IDX_W = 5;
    localparam int ROW_IDX_W  = 5;
    localparam int IMG_IDX_W  = 8;

endpackage

// File: rtl/tagged_row_fifo.sv
// Circular row buffer with a sticky overflow flag; the head entry is read straight from storage.
module tagged_row_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic                     clr_ovf_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q;
    logic             full, do_pop, do_push, drop;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));

    // A full buffer still accepts a row when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && (!full || do_pop) && !flush_i;
    assign drop    = push_i && full && !do_pop && !flush_i;

    assign count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                count_q <= count_d;
            end
            overflow_q <= drop || (overflow_q && !clr_ovf_i);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign head_o     = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Network-level controller: walks images through cascaded layers and streams final-layer rows out.
module cnn_layer_sequencer
    import cnn_pkg::*;
#(
    parameter int LAYER_NUM        = 2,
    parameter int IMAGE_NUM        = 5,
    parameter int DATA_WIDTH       = 32,
    parameter int OUT_LANES        = 12,
    parameter int TOTAL_FEATURE    = 20,
    parameter int ROWS_PER_FEATURE = 12,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            abort,
    input  logic [LAYER_NUM-1:0]            layer_calc_fin,
    output logic [LAYER_NUM-1:0]            layer_en,
    input  logic                            row_valid,
    input  logic [OUT_LANES*DATA_WIDTH-1:0] row_data,
    input  logic [FEAT_IDX_W-1:0]           row_feature,
    input  logic [ROW_IDX_W-1:0]            row_idx,
    output logic                            stall,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [OUT_LANES*DATA_WIDTH-1:0] out_data,
    output logic [FEAT_IDX_W-1:0]           out_feature,
    output logic [ROW_IDX_W-1:0]            out_row,
    output logic                            out_last,
    output logic [IMG_IDX_W-1:0]            image_idx,
    output logic                            busy,
    output logic                            done,
    output logic                            overflow
);

    localparam int LIDX_W  = (LAYER_NUM > 1) ? $clog2(LAYER_NUM) : 1;
    localparam int ROW_W   = OUT_LANES * DATA_WIDTH;
    localparam int ENTRY_W = ROW_W + FEAT_IDX_W + ROW_IDX_W + 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    localparam logic [LIDX_W-1:0]     LAST_LAYER = LIDX_W'(LAYER_NUM - 1);
    localparam logic [IMG_IDX_W-1:0]  LAST_IMAGE = IMG_IDX_W'(IMAGE_NUM - 1);
    localparam logic [FEAT_IDX_W-1:0] LAST_FEAT  = FEAT_IDX_W'(TOTAL_FEATURE - 1);
    localparam logic [ROW_IDX_W-1:0]  LAST_ROW   = ROW_IDX_W'(ROWS_PER_FEATURE - 1);

    seq_state_t             state_q;
    logic [LIDX_W-1:0]      layer_idx_q;
    logic [IMG_IDX_W-1:0]   image_q;
    logic [LAYER_NUM-1:0]   layer_en_q;
    logic                   done_q;

    logic                   active_fin, kill, clr_ovf;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic [ENTRY_W-1:0]     push_entry, head_entry;
    logic                   last_at_push;

    function automatic logic [LAYER_NUM-1:0] onehot(input logic [LIDX_W-1:0] idx);
        return LAYER_NUM'(1) << idx;
    endfunction

    // Only the completion pulse of the currently enabled layer can advance the sequence.
    assign active_fin = layer_calc_fin[layer_idx_q];
    assign kill       = abort && (state_q != IDLE);
    assign clr_ovf    = start && (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            layer_idx_q <= '0;
            image_q     <= '0;
            layer_en_q  <= '0;
            done_q      <= 1'b0;
        end else if (kill) begin
            state_q    <= IDLE;
            layer_en_q <= '0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q     <= RUN;
                        layer_idx_q <= '0;
                        image_q     <= '0;
                        layer_en_q  <= onehot('0);
                    end
                end
                RUN: begin
                    if (active_fin) begin
                        state_q    <= NEXT;
                        layer_en_q <= '0;
                    end
                end
                NEXT: begin
                    if (layer_idx_q < LAST_LAYER) begin
                        layer_idx_q <= layer_idx_q + LIDX_W'(1);
                        layer_en_q  <= onehot(layer_idx_q + LIDX_W'(1));
                        state_q     <= RUN;
                    end else if (image_q < LAST_IMAGE) begin
                        image_q     <= image_q + IMG_IDX_W'(1);
                        layer_idx_q <= '0;
                        layer_en_q  <= onehot('0);
                        state_q     <= RUN;
                    end else begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty && !row_valid) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The last-row tag is fixed when a row enters the buffer, not recomputed at the head.
    assign last_at_push = (row_feature == LAST_FEAT) && (row_idx == LAST_ROW);
    assign push_entry   = {row_data, row_feature, row_idx, last_at_push};

    tagged_row_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (row_valid),
        .din_i      (push_entry),
        .pop_i      (out_valid && out_ready),
        .flush_i    (kill),
        .clr_ovf_i  (clr_ovf),
        .head_o     (head_entry),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count),
        .overflow_o (overflow)
    );

    assign {out_data, out_feature, out_row, out_last} = head_entry;
    assign out_valid = !fifo_empty;
    assign stall     = (fifo_count >= CNT_W'(FIFO_DEPTH - 1));
    assign layer_en  = layer_en_q;
    assign image_idx = image_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed/randomised bench for cnn_layer_sequencer with a queue-based model of the output buffer.
module tb_cnn_layer_sequencer;

    localparam int LN  = 2;
    localparam int IN  = 5;
    localparam int DW  = 32;
    localparam int OL  = 12;
    localparam int TF  = 20;
    localparam int RPF = 12;
    localparam int FD  = 4;
    localparam int RW  = OL * DW;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [LN-1:0] layer_calc_fin;
    logic [LN-1:0] layer_en;
    logic          row_valid;
    logic [RW-1:0] row_data;
    logic [4:0]    row_feature;
    logic [4:0]    row_idx;
    logic          stall;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_data;
    logic [4:0]    out_feature;
    logic [4:0]    out_row;
    logic          out_last;
    logic [7:0]    image_idx;
    logic          busy;
    logic          done;
    logic          overflow;

    cnn_layer_sequencer #(
        .LAYER_NUM        (LN),
        .IMAGE_NUM        (IN),
        .DATA_WIDTH       (DW),
        .OUT_LANES        (OL),
        .TOTAL_FEATURE    (TF),
        .ROWS_PER_FEATURE (RPF),
        .FIFO_DEPTH       (FD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .layer_calc_fin (layer_calc_fin),
        .layer_en       (layer_en),
        .row_valid      (row_valid),
        .row_data       (row_data),
        .row_feature    (row_feature),
        .row_idx        (row_idx),
        .stall          (stall),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_feature    (out_feature),
        .out_row        (out_row),
        .out_last       (out_last),
        .image_idx      (image_idx),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0] d;
        logic [4:0]    f;
        logic [4:0]    r;
    } row_t;

    row_t q[$];
    bit   m_ovf;
    bit   m_busy;
    bit   rand_rows;
    int   checks;
    int   failures;
    int   done_cnt;

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LN-1:0] oh(input int l);
        return LN'(1 << l);
    endfunction

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] r;
        for (int i = 0; i < OL; i++) r[i*DW +: DW] = $urandom;
        return r;
    endfunction

    task automatic set_row(input logic [4:0] f, input logic [4:0] r);
        row_valid   = 1'b1;
        row_data    = rand_row();
        row_feature = f;
        row_idx     = r;
    endtask

    task automatic check_fifo();
        chk("out_valid", out_valid, q.size() > 0);
        chk("stall", stall, q.size() >= FD - 1);
        chk("overflow", overflow, m_ovf);
        if (q.size() > 0) begin
            chk("out_data", out_data, q[0].d);
            chk("out_feature", out_feature, q[0].f);
            chk("out_row", out_row, q[0].r);
            chk("out_last", out_last, (q[0].f == TF - 1) && (q[0].r == RPF - 1));
        end
    endtask

    // One clock: optional random row traffic, model update at the edge, checks 1 time unit later.
    task automatic tick();
        bit   v, rdy, clr, fl, pop;
        row_t nr;
        if (rand_rows) begin
            if ($urandom_range(0, 2) == 0) set_row(5'($urandom_range(0, TF - 1)), 5'($urandom_range(0, RPF - 1)));
            else row_valid = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
        end
        v    = row_valid;
        rdy  = out_ready;
        clr  = start && !m_busy;
        fl   = abort && m_busy;
        nr.d = row_data;
        nr.f = row_feature;
        nr.r = row_idx;
        @(posedge clk);
        if (clr) m_ovf = 1'b0;
        if (fl) begin
            q.delete();
        end else begin
            pop = (q.size() > 0) && rdy;
            if (pop) void'(q.pop_front());
            if (v) begin
                if (q.size() < FD) q.push_back(nr);
                else m_ovf = 1'b1;
            end
        end
        #1;
        check_fifo();
    endtask

    task automatic run_layer(input int img, input int l, input int dly, input bit poke);
        chk("layer_en_on", layer_en, oh(l));
        chk("image_idx", image_idx, img);
        chk("busy_run", busy, 1'b1);
        for (int k = 1; k < dly; k++) begin
            layer_calc_fin = LN'($urandom) & ~oh(l);
            start = poke && (k == 1);
            tick();
            chk("layer_en_hold", layer_en, oh(l));
            chk("image_idx_hold", image_idx, img);
        end
        start          = 1'b0;
        layer_calc_fin = oh(l);
        tick();
        layer_calc_fin = '0;
        chk("layer_en_gap", layer_en, '0);
        tick();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        row_valid = 1'b0;
        out_ready = 1'b1;
        while (q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_empty", out_valid, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_layer_en"}, layer_en, '0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_stall"}, stall, 1'b0);
        chk({tag, "_overflow"}, overflow, 1'b0);
        chk({tag, "_image_idx"}, image_idx, '0);
        chk({tag, "_out_data"}, out_data, '0);
        chk({tag, "_out_feature"}, out_feature, '0);
        chk({tag, "_out_row"}, out_row, '0);
        chk({tag, "_out_last"}, out_last, 1'b0);
    endtask

    initial begin
        int saved_done;
        checks         = 0;
        failures       = 0;
        done_cnt       = 0;
        m_ovf          = 1'b0;
        m_busy         = 1'b0;
        rand_rows      = 1'b0;
        rst_n          = 1'b1;
        start          = 1'b0;
        abort          = 1'b0;
        layer_calc_fin = '0;
        row_valid      = 1'b0;
        row_data       = '0;
        row_feature    = '0;
        row_idx        = '0;
        out_ready      = 1'b0;

        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check_all_zero("post_reset");

        // Last-row tagging and push+pop while full.
        out_ready = 1'b0;
        set_row(5'($urandom_range(0, TF - 2)), 5'($urandom_range(0, RPF - 1)));
        tick();
        set_row(5'(TF - 1), 5'(RPF - 1));
        tick();
        set_row(5'(TF - 1), 5'($urandom_range(0, RPF - 2)));
        tick();
        set_row(5'($urandom_range(0, TF - 2)), 5'(RPF - 1));
        tick();
        chk("full_stall", stall, 1'b1);
        set_row(5'($urandom_range(0, TF - 2)), 5'($urandom_range(0, RPF - 1)));
        out_ready = 1'b1;
        tick();
        chk("pushpop_full_stall", stall, 1'b1);
        chk("pushpop_full_no_ovf", overflow, 1'b0);
        drain(10);

        // Fill past capacity with no consumer; the fifth row is dropped.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_row(5'($urandom_range(0, TF - 1)), 5'($urandom_range(0, RPF - 1)));
            tick();
            if (i == 2) chk("stall_after_3", stall, 1'b1);
            if (i == 3) chk("no_ovf_at_4", overflow, 1'b0);
        end
        chk("ovf_after_5", overflow, 1'b1);
        drain(10);
        chk("ovf_sticky", overflow, 1'b1);

        // Full run: 5 images x 2 layers, fin 10 cycles after enable.
        rand_rows = 1'b1;
        start = 1'b1;
        tick();
        start  = 1'b0;
        m_busy = 1'b1;
        chk("start_clears_ovf", overflow, m_ovf);
        for (int img = 0; img < IN; img++) begin
            if (img == IN - 1) begin
                rand_rows = 1'b0;
                row_valid = 1'b0;
                out_ready = 1'b1;
            end
            for (int l = 0; l < LN; l++) run_layer(img, l, 10, (img == 1) && (l == 0));
        end
        saved_done = done_cnt;
        chk("drain_done", done, 1'b0);
        chk("drain_busy", busy, 1'b1);
        tick();
        chk("done_pulse", done, 1'b1);
        tick();
        m_busy = 1'b0;
        chk("done_low", done, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk("image_idx_final", image_idx, IN - 1);
        chk("done_count", done_cnt, saved_done + 1);

        // Abort during layer 1 of image 2, then restart.
        rand_rows = 1'b1;
        start = 1'b1;
        tick();
        start  = 1'b0;
        m_busy = 1'b1;
        run_layer(0, 0, $urandom_range(1, 4), 1'b0);
        run_layer(0, 1, $urandom_range(1, 4), 1'b0);
        run_layer(1, 0, $urandom_range(1, 4), 1'b0);
        run_layer(1, 1, $urandom_range(1, 4), 1'b0);
        run_layer(2, 0, $urandom_range(1, 4), 1'b0);
        rand_rows = 1'b0;
        out_ready = 1'b0;
        chk("pre_abort_en", layer_en, oh(1));
        chk("pre_abort_img", image_idx, 2);
        set_row(5'($urandom_range(0, TF - 1)), 5'($urandom_range(0, RPF - 1)));
        tick();
        row_valid = 1'b0;
        chk("pre_abort_valid", out_valid, 1'b1);
        saved_done = done_cnt;
        abort = 1'b1;
        tick();
        abort  = 1'b0;
        m_busy = 1'b0;
        chk("abort_en", layer_en, '0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_valid", out_valid, 1'b0);
        tick();
        tick();
        chk("abort_no_done", done_cnt, saved_done);
        start = 1'b1;
        tick();
        start  = 1'b0;
        m_busy = 1'b1;
        chk("restart_img", image_idx, 0);
        chk("restart_en", layer_en, oh(0));
        chk("restart_busy", busy, 1'b1);

        // Asynchronous reset mid-run with rows buffered.
        out_ready = 1'b0;
        set_row(5'($urandom_range(0, TF - 1)), 5'($urandom_range(0, RPF - 1)));
        tick();
        set_row(5'($urandom_range(0, TF - 1)), 5'($urandom_range(0, RPF - 1)));
        tick();
        row_valid = 1'b0;
        chk("half_full_valid", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        q.delete();
        m_ovf  = 1'b0;
        m_busy = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stay_idle_busy", busy, 1'b0);
            chk("stay_idle_en", layer_en, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cnn_layer_sequencer.md
Name: cnn_layer_sequencer

Overview:
- Parametrised network controller for the MNIST CNN datapath, one level above the conv/pool layers.
- Sequences IMAGE_NUM images through LAYER_NUM cascaded layers using level enables and calc_fin pulses.
- Buffers the final layer's row outputs in a tagged FIFO with a valid/ready output stream and backpressure stall.
- Supports abort, reports overflow, and signals done only after the output drains.

Parameters:
- LAYER_NUM, 2, number of sequenced layers (1..8).
- IMAGE_NUM, 5, images per run (1..256).
- DATA_WIDTH, 32, element width.
- OUT_LANES, 12, elements per output row.
- TOTAL_FEATURE, 20, feature maps at the final layer.
- ROWS_PER_FEATURE, 12, rows per final feature map.
- FIFO_DEPTH, 4, output row buffer entries (power of two, ≥2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a run; single-cycle pulse, sampled in IDLE only
- abort  in  1  synchronous abort of the current run
- layer_calc_fin  in  LAYER_NUM  per-layer completion pulse
- layer_en  out  LAYER_NUM  one-hot level enable for the active layer
- row_valid  in  1  final-layer row strobe
- row_data  in  OUT_LANES*DATA_WIDTH  final-layer row
- row_feature  in  5  feature index of row_data
- row_idx  in  5  row index of row_data
- stall  out  1  asserted when FIFO count ≥ FIFO_DEPTH-1
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accept
- out_data  out  OUT_LANES*DATA_WIDTH  head row
- out_feature  out  5  head feature tag
- out_row  out  5  head row tag
- out_last  out  1  head is feature TOTAL_FEATURE-1, row ROWS_PER_FEATURE-1
- image_idx  out  8  current image
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at end of run
- overflow  out  1  sticky: row dropped while full

Behaviour:
- Reset: state IDLE; all outputs 0. This includes layer_en, image_idx, FIFO pointers/count, and overflow.
- FSM states: IDLE, RUN, NEXT, DRAIN, DONE.
- IDLE:
  - start → RUN.
  - layer_idx=0, image_idx=0, overflow cleared.
  - layer_en[0] rises the cycle after start (latency 1).
- RUN:
  - layer_en = one-hot(layer_idx), held.
  - On layer_calc_fin[layer_idx], go to NEXT; layer_en goes 0 the next cycle.
  - layer_calc_fin bits for non-active layers are ignored.
- NEXT: one idle gap cycle; all enables 0.
  - If layer_idx < LAYER_NUM-1: layer_idx++, → RUN.
  - Else if image_idx < IMAGE_NUM-1: image_idx++, layer_idx=0, → RUN.
  - Else → DRAIN.
- DRAIN: wait until FIFO empty and no row_valid, then → DONE.
- DONE: done=1 for one cycle, → IDLE; image_idx holds its final value until the next start.
- start while busy: ignored.
- abort (any non-IDLE state, highest priority):
  - Next cycle: state IDLE, layer_en=0, FIFO flushed.
  - No done pulse; overflow retained.
- FIFO:
  - Push on row_valid, storing {data, feature, row}.
  - Pop on out_valid && out_ready.
  - out_* driven from the head register, no combinational path from inputs.
  - First-word latency: 1 cycle.
  - Push while full with a simultaneous pop: accepted.
  - Push while full without a pop: row dropped, overflow set to 1.
  - Pointers wrap modulo FIFO_DEPTH.
  - Count width is clog2(FIFO_DEPTH)+1.
- Rows arriving in IDLE are still buffered; the FIFO is independent of the FSM except for flush.
- out_last is computed at push time and stored per entry.
- Asynchronous reset mid-run: immediate return to reset values.

Decomposition:
- Shared package cnn_pkg: state enum seq_state_t (IDLE, RUN, NEXT, DRAIN, DONE) and width constants FEAT_IDX_W=5, ROW_IDX_W=5, IMG_IDX_W=8.
- Sub-module tagged_row_fifo (parameters WIDTH, DEPTH): push/pop/flush, full/empty/count, and the overflow flag.

Test Plan:
- LAYER_NUM=2, IMAGE_NUM=5; start; each fin pulsed 10 cycles after its enable → layer_en pattern 01,00,10,00 repeats 5 times; image_idx 0..4; done pulses once, 2 cycles after the last fin with FIFO empty.
- Push 4 rows with out_ready=0, FIFO_DEPTH=4 → stall=1 after the 3rd push; 5th push sets overflow=1; draining yields rows 1-4 in order.
- Push the row with feature 19, row 11 → out_last=1 on that entry only; push+pop same cycle while full → count stays 4, no overflow.
- Assert abort during layer 1 of image 2 → next cycle layer_en=0, busy=0, out_valid=0, no done pulse; a following start restarts at image 0.
- Pulse layer_calc_fin[1] while layer 0 is active → ignored; state stays RUN with layer_en=01.
- Drop rst_n mid-run with the FIFO half full → all outputs 0 asynchronously; after release the block stays in IDLE until start.
